// File: rtl/key_process_pkg.sv
// Shared lock package: key/store geometry used by key_process and the lock FSM,
// plus the per-cycle action decoded by the key front end.
package key_process_pkg;

  localparam int LOCK_KEY_WIDTH   = 4;
  localparam int LOCK_KEY_NUMBERS = 6;
  localparam int LOCK_STORE_WIDTH = LOCK_KEY_WIDTH * LOCK_KEY_NUMBERS;

  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_ACCEPT,
    ACT_CLEAR_FULL,
    ACT_DISCARD,
    ACT_TIMEOUT
  } key_action_e;

endpackage

// File: rtl/key_process_edge_detect.sv
// Turns the raw key bus into a single-cycle press pulse on a 0 -> nonzero change.
module key_process_edge_detect #(
  parameter int KEY_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key_i,
  output logic                 press_o
);

  logic [KEY_WIDTH-1:0] prev_key_q;
  logic                 armed_q;

  // armed_q stays low until the bus has been seen idle, so a key held through
  // reset release never looks like a fresh press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_key_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      prev_key_q <= key_i;
      armed_q    <= armed_q | ~(|key_i);
    end
  end

  assign press_o = armed_q & (|key_i) & ~(|prev_key_q);

endmodule

// File: rtl/key_process.sv
// Key-entry front end: press events shift codes into a KEY_NUMBERS-deep store,
// with an inter-key timeout that empties the store and raises timeValueFlag.
module key_process
  import key_process_pkg::*;
#(
  parameter int KEY_WIDTH               = LOCK_KEY_WIDTH,
  parameter int KEY_NUMBERS             = LOCK_KEY_NUMBERS,
  parameter int KEY_NUMBERS_STORE_WIDTH = 3,
  parameter int CLOCK_FREQUENCY         = 50_000_000,
  parameter int CLOCK_COUNT_SOTRE_WIDTH = 40,
  parameter int TIME_OUTS_TIME          = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [KEY_WIDTH-1:0]                 keyInputValue,
  output logic [KEY_WIDTH*KEY_NUMBERS-1:0]     keyValueStore,
  output logic                                 timeValueFlag,
  output logic [KEY_NUMBERS_STORE_WIDTH-1:0]   keyNumbersStore
);

  localparam int     STORE_W = KEY_WIDTH * KEY_NUMBERS;
  localparam int     CW      = CLOCK_COUNT_SOTRE_WIDTH;
  localparam int     NW      = KEY_NUMBERS_STORE_WIDTH;
  localparam longint TLIM_L  = longint'(CLOCK_FREQUENCY) * longint'(TIME_OUTS_TIME);
  localparam logic [CW-1:0] TLIM    = CW'(TLIM_L);
  localparam logic [CW-1:0] TLIM_M1 = CW'(TLIM_L - 1);
  localparam logic [NW-1:0] FULL    = NW'(KEY_NUMBERS);

  logic               press;
  logic [CW-1:0]      timer_q, timer_d;
  logic [STORE_W-1:0] store_q, store_d;
  logic [NW-1:0]      count_q, count_d;
  logic               flag_q, flag_d;
  logic               rearm_q, rearm_d;
  logic               timeout_hit;
  key_action_e        action;

  key_process_edge_detect #(
    .KEY_WIDTH (KEY_WIDTH)
  ) u_edge (
    .clock   (clock),
    .reset   (reset),
    .key_i   (keyInputValue),
    .press_o (press)
  );

  // Timer: cleared by any press, otherwise counts up and parks at TLIM.
  always_comb begin
    timer_d = timer_q;
    if (press)               timer_d = '0;
    else if (timer_q != TLIM) timer_d = timer_q + CW'(1);
  end

  // The timeout fires on the edge where the timer steps onto TLIM; a press on
  // that same edge wins and the timeout is skipped.
  assign timeout_hit = ~press & (timer_q == TLIM_M1);

  // After a timeout, the first press only re-arms entry (rearm_q); the next
  // press is stored as digit 1 and drops the flag.
  always_comb begin
    action = ACT_IDLE;
    if (press) begin
      if (flag_q && !rearm_q) action = ACT_DISCARD;
      else if (count_q == FULL) action = ACT_CLEAR_FULL;
      else                      action = ACT_ACCEPT;
    end else if (timeout_hit) begin
      action = ACT_TIMEOUT;
    end
  end

  always_comb begin
    store_d = store_q;
    count_d = count_q;
    flag_d  = flag_q;
    rearm_d = rearm_q;
    case (action)
      ACT_ACCEPT: begin
        store_d = {store_q[STORE_W-KEY_WIDTH-1:0], keyInputValue};
        count_d = count_q + NW'(1);
        flag_d  = 1'b0;
        rearm_d = 1'b0;
      end
      ACT_CLEAR_FULL: begin
        store_d = '0;
        count_d = '0;
      end
      ACT_DISCARD: begin
        store_d = '0;
        count_d = '0;
        rearm_d = 1'b1;
      end
      ACT_TIMEOUT: begin
        store_d = '0;
        count_d = '0;
        flag_d  = 1'b1;
        rearm_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      store_q <= '0;
      count_q <= '0;
      flag_q  <= 1'b0;
      rearm_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      store_q <= store_d;
      count_q <= count_d;
      flag_q  <= flag_d;
      rearm_q <= rearm_d;
    end
  end

  assign keyValueStore   = store_q;
  assign keyNumbersStore = count_q;
  assign timeValueFlag   = flag_q;

endmodule

// File: tb/tb_key_process.sv
// Directed bench for key_process with a short timeout (TLIM = 200 cycles).
module tb_key_process;

  localparam int TLIM = 200;

  logic        clock;
  logic        reset;
  logic [3:0]  keyInputValue;
  logic [23:0] keyValueStore;
  logic        timeValueFlag;
  logic [2:0]  keyNumbersStore;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  key;
    int          hold;
    logic [23:0] store;
    logic [2:0]  count;
    logic        flag;
  } vec_t;

  vec_t vecs [7];

  key_process #(
    .KEY_WIDTH               (4),
    .KEY_NUMBERS             (6),
    .KEY_NUMBERS_STORE_WIDTH (3),
    .CLOCK_FREQUENCY         (TLIM),
    .CLOCK_COUNT_SOTRE_WIDTH (40),
    .TIME_OUTS_TIME          (1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .keyInputValue   (keyInputValue),
    .keyValueStore   (keyValueStore),
    .timeValueFlag   (timeValueFlag),
    .keyNumbersStore (keyNumbersStore)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [23:0] s, input logic [2:0] c,
                            input logic f);
    check({name, "_store"}, 32'(keyValueStore), 32'(s));
    check({name, "_count"}, 32'(keyNumbersStore), 32'(c));
    check({name, "_flag"},  32'(timeValueFlag), 32'(f));
  endtask

  // Drive a key on a falling edge, hold it, release it and let outputs settle.
  task automatic press_key(input logic [3:0] k, input int hold);
    @(negedge clock);
    keyInputValue = k;
    repeat (hold) @(negedge clock);
    keyInputValue = 4'h0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    vecs[0] = '{4'b0001, 10, 24'h000001, 3'd1, 1'b0};
    vecs[1] = '{4'b0010, 10, 24'h000012, 3'd2, 1'b0};
    vecs[2] = '{4'b1000, 10, 24'h000128, 3'd3, 1'b0};
    vecs[3] = '{4'b0100, 10, 24'h001284, 3'd4, 1'b0};
    vecs[4] = '{4'b1000, 10, 24'h012848, 3'd5, 1'b0};
    vecs[5] = '{4'b0010, 10, 24'h128482, 3'd6, 1'b0};
    vecs[6] = '{4'b0001, 10, 24'h000000, 3'd0, 1'b0};

    reset         = 1'b1;
    keyInputValue = 4'h0;
    #12;
    check_outs("reset", 24'h0, 3'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_outs("post_reset", 24'h0, 3'd0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      press_key(vecs[i].key, vecs[i].hold);
      check_outs($sformatf("vec%0d", i), vecs[i].store, vecs[i].count, vecs[i].flag);
    end

    // Exact timeout boundary: one digit stored, then no keys.
    @(negedge clock);
    keyInputValue = 4'h5;
    @(negedge clock);
    keyInputValue = 4'h0;
    repeat (TLIM - 1) @(negedge clock);
    check_outs("pre_timeout", 24'h000005, 3'd1, 1'b0);
    @(negedge clock);
    check_outs("timeout", 24'h0, 3'd0, 1'b1);
    repeat (1000) @(negedge clock);
    check_outs("timeout_hold", 24'h0, 3'd0, 1'b1);

    press_key(4'b0100, 10);
    check_outs("discard_after_to", 24'h0, 3'd0, 1'b1);
    press_key(4'b0011, 10);
    check_outs("first_after_to", 24'h000003, 3'd1, 1'b0);

    // Direct code change without release is not a second press.
    @(negedge clock);
    keyInputValue = 4'b0001;
    repeat (50) @(negedge clock);
    keyInputValue = 4'b0010;
    repeat (50) @(negedge clock);
    keyInputValue = 4'h0;
    repeat (2) @(negedge clock);
    check_outs("no_release_change", 24'h000031, 3'd2, 1'b0);

    press_key(4'b0110, 100);
    check_outs("long_hold", 24'h000316, 3'd3, 1'b0);

    // Asynchronous reset mid-entry with a key held across release.
    @(negedge clock);
    keyInputValue = 4'b0101;
    #2 reset = 1'b1;
    #1 check_outs("async_reset", 24'h0, 3'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_outs("held_through_reset", 24'h0, 3'd0, 1'b0);
    keyInputValue = 4'h0;
    repeat (2) @(negedge clock);
    press_key(4'b1001, 10);
    check_outs("after_reset_press", 24'h000009, 3'd1, 1'b0);

    // Press landing on the very edge where the timeout would fire.
    @(negedge clock);
    keyInputValue = 4'b1010;
    @(negedge clock);
    keyInputValue = 4'h0;
    repeat (TLIM - 1) @(negedge clock);
    check_outs("prio_pre", 24'h00009A, 3'd2, 1'b0);
    keyInputValue = 4'b1100;
    @(negedge clock);
    check_outs("prio_press", 24'h0009AC, 3'd3, 1'b0);
    keyInputValue = 4'h0;
    repeat (5) @(negedge clock);
    check_outs("prio_after", 24'h0009AC, 3'd3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
